mul_appr_pipe: RTL

Pipelined, parametrised successor to the 16-bit combinational approximate multiplier. Accepts one signed or unsigned WIDTH×WIDTH multiply per cycle under valid/ready flow control. Each operation selects exact mode or lower-part-OR approximate mode. It sits between operand producers and the DFG datapath as a drop-in multiply unit with a fixed 3-cycle latency and full backpressure support.

---
 rtl/mul_appr_pipe.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mul_appr_pipe.sv
// -----------------------------------------------------------------------------
// mul_appr_pipe
//
// Pipelined WIDTH x WIDTH multiplier with per-operation selection of exact or
// lower-part-OR approximate mode. Signed operands are multiplied as
// magnitudes, and the sign is applied at the end with a conditional
// two's-complement negate.
//
// In approximate mode the partial-product columns below APPR_BITS are not
// added. Each of those columns is the OR of its row bits. The columns at or
// above APPR_BITS are summed exactly, and no carry enters them from below.
//
// Pipeline (fixed three stages, one global stall signal):
//   S1  operand magnitudes, sign of result, mode, tag
//   S2  exact high-column sum and low-column OR vector
//   S3  combined product after the conditional negate (drives out/out_tag)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operation presented
//   in_ready   operation accepted this cycle (== adv, combinational on out_ready)
//   A, B       WIDTH-bit operands
//   in_signed  1: operands are two's complement, 0: unsigned
//   in_appr    1: approximate mode, 0: exact
//   in_tag     opaque TAG_W-bit tag carried with the operation
//   out_valid  result presented
//   out_ready  consumer accepts the result
//   out        2*WIDTH-bit product
//   out_tag    tag of the operation currently in out
//   appr_cnt   approximate-mode results delivered since reset (saturating)
// -----------------------------------------------------------------------------
module mul_appr_pipe #(
    parameter int WIDTH     = 16,
    parameter int APPR_BITS = 16,
    parameter int TAG_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               in_signed,
    input  logic               in_appr,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic [TAG_W-1:0]   out_tag,
    output logic [31:0]        appr_cnt
);

    localparam int PW = 2 * WIDTH;

    // Columns that are OR-ed instead of added when approximate mode is selected.
    localparam logic [PW-1:0] LO_MASK = PW'((65'd1 << APPR_BITS) - 65'd1);

    // Global advance: the whole pipeline moves when the output slot is empty
    // or is being drained this cycle. Bubbles are kept in place.
    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------------------------------------------------------- S1 input
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             in_neg;

    // The most negative value negates to itself. Read as unsigned, that is
    // exactly its magnitude 2^(WIDTH-1).
    assign a_mag  = (in_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag  = (in_signed && B[WIDTH-1]) ? -B : B;
    assign in_neg = in_signed && (A[WIDTH-1] ^ B[WIDTH-1]);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a_mag;
    logic [WIDTH-1:0] s1_b_mag;
    logic             s1_neg;
    logic             s1_appr;
    logic [TAG_W-1:0] s1_tag;

    // ------------------------------------------------ S2 column-split reduction
    logic [PW-1:0] col_mask;
    logic [PW-1:0] row;
    logic [PW-1:0] hi_sum;
    logic [PW-1:0] lo_or;

    // NOTE: combinational blocks use blocking assignments and give every
    // target a default first, so the loop accumulates in order and no latch
    // is inferred.
    always_comb begin
        col_mask = s1_appr ? LO_MASK : '0;
        row      = '0;
        hi_sum   = '0;
        lo_or    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row    = s1_b_mag[i] ? (PW'(s1_a_mag) << i) : '0;
            hi_sum = hi_sum + (row & ~col_mask);
            lo_or  = lo_or | (row & col_mask);
        end
    end

    logic             s2_valid;
    logic [PW-1:0]    s2_hi;
    logic [PW-1:0]    s2_lo;
    logic             s2_neg;
    logic             s2_appr;
    logic [TAG_W-1:0] s2_tag;

    // ------------------------------------------------------- S3 combine/negate
    logic [PW-1:0] p_comb;
    logic [PW-1:0] result;

    // The two parts occupy disjoint columns, so OR-ing them is the same as
    // adding them. In exact mode the low vector is all zero.
    assign p_comb = s2_hi | s2_lo;
    assign result = s2_neg ? -p_comb : p_comb;

    logic out_appr;

    // -------------------------------------------------- control and outputs
    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage samples the previous value of its upstream stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            out_tag   <= '0;
            out_appr  <= 1'b0;
            appr_cnt  <= '0;
        end else begin
            if (out_valid && out_ready && out_appr && (appr_cnt != 32'hFFFF_FFFF))
                appr_cnt <= appr_cnt + 32'd1;

            if (adv) begin
                s1_valid  <= in_valid;
                s2_valid  <= s1_valid;
                out_valid <= s2_valid;
                // Bubbles leave out/out_tag at their last delivered value.
                if (s2_valid) begin
                    out      <= result;
                    out_tag  <= s2_tag;
                    out_appr <= s2_appr;
                end
            end
        end
    end

    // ------------------------------------------------------------ datapath
    // NOTE: the datapath registers have no reset. Their contents only matter
    // when the matching stage valid bit is set, and that bit is reset.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_a_mag <= a_mag;
            s1_b_mag <= b_mag;
            s1_neg   <= in_neg;
            s1_appr  <= in_appr;
            s1_tag   <= in_tag;

            s2_hi    <= hi_sum;
            s2_lo    <= lo_or;
            s2_neg   <= s1_neg;
            s2_appr  <= s1_appr;
            s2_tag   <= s1_tag;
        end
    end

endmodule
